// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: sequences SRAM read/write strobes for load, store and atomic swap.
// Optional feature: define DMEM_RANGE_CHECK_EN to fault requests whose address exceeds MEM_WORDS.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for i_req; the only state where a request is sampled
// ST_RD   | o_memRdEn held while the wait counter runs down to zero
// ST_WR   | o_memWrEn for exactly one cycle (store, or second half of swap)
// ST_ACK  | o_ack pulse; o_fault alongside it for an out-of-range access
module dmem_access_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                RD_WAIT   = 1,
  parameter logic [ADDR_W-1:0] MEM_WORDS = '1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req,
  input  logic              i_isWrite,
  input  logic              i_isSwap,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wrData,
  output logic              o_busy,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdData,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memRdEn,
  output logic              o_memWrEn,
  output logic [DATA_W-1:0] o_memWrData,
  input  logic [DATA_W-1:0] i_memRdData
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);

  if (RD_WAIT < 1 || RD_WAIT > 7) begin : g_bad_rd_wait
    $error("dmem_access_ctrl: RD_WAIT must be in 1..7");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                swap_q, swap_d;
  logic                fault_q, fault_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                req_oor;

`ifdef DMEM_RANGE_CHECK_EN
  assign req_oor = (i_addr > MEM_WORDS);
`else
  assign req_oor = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      swap_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      swap_q  <= swap_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    swap_d  = swap_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          wdata_d = i_wrData;
          swap_d  = i_isSwap;
          cnt_d   = RD_LOAD;
          fault_d = req_oor;
          if (req_oor) begin
            state_d = ST_ACK;
          end else if (i_isSwap || !i_isWrite) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        // SRAM data is only guaranteed on the final read cycle
        if (cnt_q == 3'd0) begin
          rdata_d = i_memRdData;
          state_d = swap_q ? ST_WR : ST_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR:   state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_ack       = (state_q == ST_ACK);
  assign o_fault     = fault_q && (state_q == ST_ACK);
  assign o_memRdEn   = (state_q == ST_RD);
  assign o_memWrEn   = (state_q == ST_WR);
  assign o_memAddr   = addr_q;
  assign o_memWrData = wdata_q;
  assign o_rdData    = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: two instances (RD_WAIT=1 and RD_WAIT=3) checked
// cycle by cycle against a transaction-level model with a shadow memory.
module tb_dmem_access_ctrl;

  localparam logic [15:0] MEMW = 16'h00FF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req[2], is_wr[2], is_sw[2];
  logic [15:0] addr[2], wdata[2];
  logic        busy[2], ack[2], fault[2], rd_en[2], wr_en[2];
  logic [15:0] rdata[2], m_addr[2], m_wdata[2], m_rdata[2];

  logic [15:0] mem[2][512] = '{default: '0};
  logic [15:0] shadow[2][512];
  logic [15:0] exp_rd[2];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_access_ctrl #(
      .DATA_W(16), .ADDR_W(16), .RD_WAIT(g == 0 ? 1 : 3), .MEM_WORDS(MEMW)
    ) u_dut (
      .i_clk(clk), .i_rstn(rst_n),
      .i_req(req[g]), .i_isWrite(is_wr[g]), .i_isSwap(is_sw[g]),
      .i_addr(addr[g]), .i_wrData(wdata[g]),
      .o_busy(busy[g]), .o_ack(ack[g]), .o_rdData(rdata[g]), .o_fault(fault[g]),
      .o_memAddr(m_addr[g]), .o_memRdEn(rd_en[g]), .o_memWrEn(wr_en[g]),
      .o_memWrData(m_wdata[g]), .i_memRdData(m_rdata[g])
    );
    assign m_rdata[g] = mem[g][m_addr[g][8:0]];
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (wr_en[u]) mem[u][m_addr[u][8:0]] <= m_wdata[u];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input int u, input string tag);
    check_val($sformatf("%s_busy%0d", tag, u), busy[u], 0);
    check_val($sformatf("%s_ack%0d", tag, u), ack[u], 0);
    check_val($sformatf("%s_fault%0d", tag, u), fault[u], 0);
    check_val($sformatf("%s_rden%0d", tag, u), rd_en[u], 0);
    check_val($sformatf("%s_wren%0d", tag, u), wr_en[u], 0);
    check_val($sformatf("%s_rdata%0d", tag, u), rdata[u], 0);
    check_val($sformatf("%s_maddr%0d", tag, u), m_addr[u], 0);
    check_val($sformatf("%s_mwdata%0d", tag, u), m_wdata[u], 0);
  endtask

  // kind: 0 load, 1 store, 2 swap
  task automatic run_txn(input int u, input int kind, input logic [15:0] a, input logic [15:0] d);
    int          w, last;
    bit          oor, exp_rden, exp_wren;
    logic [15:0] old_rd, new_rd;
    string       t;
    w = (u == 0) ? 1 : 3;
    oor = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (a > MEMW);
`endif
    if (oor)            last = 1;
    else if (kind == 0) last = w + 1;
    else if (kind == 1) last = 2;
    else                last = w + 2;
    old_rd = exp_rd[u];
    new_rd = (oor || kind == 1) ? old_rd : shadow[u][a[8:0]];

    @(posedge clk); #1;
    check_val($sformatf("idle_busy u%0d", u), busy[u], 0);
    req[u]   = 1'b1;
    is_sw[u] = (kind == 2);
    is_wr[u] = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    addr[u]  = a;
    wdata[u] = d;

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      t = $sformatf("u%0d k%0d a%0h kind%0d", u, k, a, kind);
      exp_rden = !oor && kind != 1 && k <= w;
      exp_wren = !oor && ((kind == 1 && k == 1) || (kind == 2 && k == w + 1));
      check_val({"rden ", t}, rd_en[u], exp_rden);
      check_val({"wren ", t}, wr_en[u], exp_wren);
      check_val({"ack ", t}, ack[u], k == last);
      check_val({"busy ", t}, busy[u], 1);
      check_val({"fault ", t}, fault[u], oor && k == last);
      check_val({"maddr ", t}, m_addr[u], a);
      check_val({"mwdata ", t}, m_wdata[u], d);
      if (k == last)                 check_val({"rdata ", t}, rdata[u], new_rd);
      else if (kind == 1 || k <= w)  check_val({"rdata_hold ", t}, rdata[u], old_rd);
      // latched copies must be used, so scramble the inputs while busy
      req[u]   = (k == last) ? 1'b0 : 1'($urandom_range(0, 1));
      addr[u]  = 16'($urandom);
      wdata[u] = 16'($urandom);
      is_wr[u] = 1'($urandom_range(0, 1));
      is_sw[u] = 1'($urandom_range(0, 1));
    end

    if (!oor && kind != 0) shadow[u][a[8:0]] = d;
    exp_rd[u] = new_rd;
    check_val($sformatf("mem u%0d a%0h", u, a), mem[u][a[8:0]], shadow[u][a[8:0]]);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 0; is_wr[u] = 0; is_sw[u] = 0; addr[u] = '0; wdata[u] = '0; exp_rd[u] = '0;
      for (int i = 0; i < 512; i++) shadow[u][i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero(0, "rst");
    check_all_zero(1, "rst");
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_txn(0, 1, 16'h0010, 16'hBEEF);
    run_txn(0, 0, 16'h0010, 16'h0000);
    run_txn(0, 1, 16'h0020, 16'h1234);
    run_txn(1, 1, 16'h0030, 16'hAAAA);
    run_txn(1, 2, 16'h0030, 16'h5555);
    run_txn(1, 0, 16'h0030, 16'h0000);
    run_txn(0, 0, 16'h0100, 16'h0000);
    run_txn(1, 2, 16'h0100, 16'h6789);

    for (int i = 0; i < 160; i++) begin
      int          u, kind;
      logic [15:0] a;
      u    = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      a    = {8'h00, 8'($urandom)};
      if ($urandom_range(0, 7) == 0) a = a + 16'h0100;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      run_txn(u, kind, a, 16'($urandom));
    end

    // reset during the write half of a swap on the RD_WAIT=3 instance
    run_txn(1, 1, 16'h0040, 16'h7777);
    @(posedge clk); #1;
    req[1] = 1'b1; is_sw[1] = 1'b1; is_wr[1] = 1'b0; addr[1] = 16'h0040; wdata[1] = 16'h9999;
    @(posedge clk); #1;
    req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rstwr wren_before", wr_en[1], 1);
    rst_n = 1'b0;
    #1;
    check_all_zero(1, "rstwr");
    check_all_zero(0, "rstwr");
    @(posedge clk); #1;
    check_val("rstwr mem_kept", mem[1][9'h040], 16'h7777);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("rstwr no_ack k%0d", k), ack[1], 0);
      check_val($sformatf("rstwr idle k%0d", k), busy[1], 0);
    end
    run_txn(1, 0, 16'h0040, 16'h0000);
    run_txn(0, 2, 16'h0041, 16'h1357);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
